// File: rtl/cpu_clk_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_clk_ctrl
//   CPU clock-enable controller. All CPU timing is expressed as single-cycle
//   enable pulses on i_sysclk instead of derived clocks. A small FSM sequences
//   the CPU through HALT / RUN / STEP. The CPU divide ratio can be reloaded at
//   runtime over a valid/ready handshake, accepted only while halted. An
//   independent free-running divider produces the LED scan tick.
//
//   Optional feature macro: CLKCTRL_CYCLE_CNT_EN
//     defined   -> o_cycle_count port and 32-bit issued-cycle counter exist
//     undefined -> port and counter are absent, all else identical
//
// Parameters
//   DIV_DEFAULT  reset divide ratio (sysclk cycles per CPU cycle)
//   LED_DIV      sysclk cycles per o_led_tick pulse (>= 1)
//   CNT_W        width of the divide ratio and phase counter
//
// Ports
//   i_sysclk       system clock, everything on the rising edge
//   i_reset        synchronous active-high reset
//   i_run          level, 1 = free-run request
//   i_step_req     level, each rising edge requests one CPU cycle
//   i_cfg_valid    divide-ratio load request
//   i_cfg_div      new divide ratio (0 is treated as 1)
//   o_cfg_ready    load accepted this cycle if i_cfg_valid (HALT only)
//   o_cpu_en       one-sysclk CPU clock-enable pulse
//   o_step_done    one-sysclk pulse, single step executed
//   o_led_tick     one-sysclk LED scan pulse
//   o_mode         current state: 0 HALT, 1 RUN, 2 STEP
//   o_cycle_count  CPU cycles issued (CLKCTRL_CYCLE_CNT_EN only)
// ---------------------------------------------------------------------------
module cpu_clk_ctrl #(
  parameter int unsigned DIV_DEFAULT = 50_000_000,
  parameter int unsigned LED_DIV     = 50_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_sysclk,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_step_req,
  input  logic             i_cfg_valid,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cpu_en,
  output logic             o_step_done,
  output logic             o_led_tick,
  output logic [1:0]       o_mode
`ifdef CLKCTRL_CYCLE_CNT_EN
  ,
  output logic [31:0]      o_cycle_count
`endif
);

  // Divide ratio of 0 is meaningless; treat it as 1 both at reset and on load.
  localparam logic [CNT_W-1:0] DIV_RST =
    (DIV_DEFAULT == 0) ? CNT_W'(1) : CNT_W'(DIV_DEFAULT);

  localparam int unsigned      LED_W    = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
  localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_DIV - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_phase;
  logic             r_step_prev;
  logic             r_cpu_en;
  logic             r_step_done;
  logic [LED_W-1:0] r_led_cnt;
  logic             r_led_tick;

  logic             w_step_edge;
  logic             w_cfg_fire;
  logic [CNT_W-1:0] w_cfg_div_clamp;
  logic [CNT_W-1:0] w_div_eff;
  logic [CNT_W-1:0] w_div_last;
  logic [CNT_W-1:0] w_phase_nxt;
  logic [LED_W-1:0] w_led_nxt;

  // Handshake and step-edge decode.
  assign w_step_edge     = i_step_req & ~r_step_prev;
  assign w_cfg_fire      = i_cfg_valid & o_cfg_ready;
  assign w_cfg_div_clamp = (i_cfg_div == '0) ? CNT_W'(1) : i_cfg_div;

  // A load coinciding with HALT->RUN must already govern the first RUN period.
  assign w_div_eff  = w_cfg_fire ? w_cfg_div_clamp : r_div;
  assign w_div_last = r_div - CNT_W'(1);

  // Phase advance in RUN; >= guards against any phase beyond the ratio.
  assign w_phase_nxt = (r_phase >= w_div_last) ? '0 : r_phase + CNT_W'(1);

  // The enable is registered one cycle ahead: it is set when the phase being
  // loaded equals N-1, so the pulse coincides with the cycle whose phase is N-1.
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_state     <= ST_HALT;
      r_div       <= DIV_RST;
      r_phase     <= '0;
      r_step_prev <= 1'b0;
      r_cpu_en    <= 1'b0;
      r_step_done <= 1'b0;
    end else begin
      r_step_prev <= i_step_req;
      r_cpu_en    <= 1'b0;
      r_step_done <= 1'b0;
      if (w_cfg_fire) begin
        r_div <= w_cfg_div_clamp;
      end
      case (r_state)
        ST_HALT: begin
          r_phase <= '0;
          if (i_run) begin
            r_state  <= ST_RUN;
            r_cpu_en <= (w_div_eff == CNT_W'(1));
          end else if (w_step_edge) begin
            r_state     <= ST_STEP;
            r_cpu_en    <= 1'b1;
            r_step_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!i_run) begin
            // A pulse already issued for this cycle stands; nothing follows.
            r_state <= ST_HALT;
            r_phase <= '0;
          end else begin
            r_phase  <= w_phase_nxt;
            r_cpu_en <= (w_phase_nxt == w_div_last);
          end
        end
        ST_STEP: begin
          r_state <= ST_HALT;
          r_phase <= '0;
        end
        default: begin
          r_state <= ST_HALT;
          r_phase <= '0;
        end
      endcase
    end
  end

  // Free-running LED divider, same one-ahead registration as the CPU enable.
  assign w_led_nxt = (r_led_cnt == LED_LAST) ? '0 : r_led_cnt + LED_W'(1);

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_led_cnt  <= '0;
      r_led_tick <= 1'b0;
    end else begin
      r_led_cnt  <= w_led_nxt;
      r_led_tick <= (w_led_nxt == LED_LAST);
    end
  end

`ifdef CLKCTRL_CYCLE_CNT_EN
  logic [31:0] r_cycle_count;

  // Counts each issued enable pulse; wraps naturally at 2^32.
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_cycle_count <= '0;
    end else if (r_cpu_en) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign o_cycle_count = r_cycle_count;
`endif

  assign o_cfg_ready = (r_state == ST_HALT);
  assign o_mode      = 2'(r_state);
  assign o_cpu_en    = r_cpu_en;
  assign o_step_done = r_step_done;
  assign o_led_tick  = r_led_tick;

endmodule
